// File: rtl/chi_plane_sched_if.sv
// Plane load and result hand-off between the round-state register and chi_plane_sched.
// master = round-state side, slave = the sequencer.
interface chi_plane_sched_if #(
    parameter int unsigned NUM_ROWS = 5
);
    localparam int unsigned PW = 5 * NUM_ROWS;

    logic          load_valid;
    logic          load_ready;
    logic [PW-1:0] plane1;
    logic [PW-1:0] plane2;
    logic [PW-1:0] plane3;
    logic          res_valid;
    logic          res_ready;
    logic [PW-1:0] res1;
    logic [PW-1:0] res2;
    logic [PW-1:0] res3;

    modport master (
        output load_valid, plane1, plane2, plane3, res_ready,
        input  load_ready, res_valid, res1, res2, res3
    );

    modport slave (
        input  load_valid, plane1, plane2, plane3, res_ready,
        output load_ready, res_valid, res1, res2, res3
    );
endinterface

// File: rtl/chi_plane_sched.sv
// Streams one 3-share Keccak plane row by row through a shared registered chi core
// and returns the captured result shares over a valid/ready handshake.
module chi_plane_sched #(
    parameter int unsigned NUM_ROWS = 5,
    parameter int unsigned LAT      = 1,
    parameter bit          REV_OUT  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              abort,
    chi_plane_sched_if.slave  bus,
    output logic [4:0]        core_in1,
    output logic [4:0]        core_in2,
    output logic [4:0]        core_in3,
    input  logic [4:0]        core_out1,
    input  logic [4:0]        core_out2,
    input  logic [4:0]        core_out3,
    output logic              busy
);
    localparam int unsigned RW = 5;
    localparam int unsigned NS = 3;
    localparam int unsigned CW = $clog2(NUM_ROWS + 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(NUM_ROWS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD} state_t;
    typedef logic [RW-1:0] row_t;
    typedef logic [NUM_ROWS-1:0][RW-1:0] plane_t;

    state_t          state_q;
    state_t          state_d;
    logic            load_ready_q;
    logic            load_ready_d;
    logic            busy_q;
    logic            busy_d;
    logic            res_valid_q;
    logic            res_valid_d;

    plane_t          plane_in  [NS];
    plane_t          plane_q   [NS];
    plane_t          res_q     [NS];
    row_t            core_in_q [NS];
    row_t            core_out  [NS];
    row_t            issue_row [NS];
    row_t            cap_row   [NS];
    logic [CW-1:0]   ir_q;
    logic [CW-1:0]   ir_next;
    logic [CW-1:0]   cr_q;
    logic            issue_q;
    logic            issue_d;
    logic [LAT-1:0]  cap_pipe_q;
    logic            cap;
    logic            last_cap;
    logic            last_issue;

    function automatic row_t rev_row(input row_t x);
        row_t y;
        for (int unsigned i = 0; i < RW; i++) begin
            y[i] = x[RW-1-i];
        end
        return y;
    endfunction

    assign plane_in[0] = bus.plane1;
    assign plane_in[1] = bus.plane2;
    assign plane_in[2] = bus.plane3;
    assign core_out[0] = core_out1;
    assign core_out[1] = core_out2;
    assign core_out[2] = core_out3;

    assign ir_next    = ir_q + CW'(1);
    assign last_issue = (state_q == S_ISSUE) && (ir_q == LAST_ROW);
    // The oldest bit of the issue-valid pipe marks a core output that belongs to us.
    assign cap        = cap_pipe_q[LAT-1];
    assign last_cap   = cap && (cr_q == LAST_ROW);

    // State register
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.load_valid) state_d = S_ISSUE;
            S_ISSUE: if (last_issue)     state_d = S_DRAIN;
            S_DRAIN: if (last_cap)       state_d = S_HOLD;
            S_HOLD:  if (bus.res_ready)  state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
        end
    end

    // Handshake/status outputs follow the state being entered
    always_comb begin
        load_ready_d = 1'b0;
        busy_d       = 1'b0;
        res_valid_d  = 1'b0;
        case (state_d)
            S_IDLE:           load_ready_d = 1'b1;
            S_ISSUE, S_DRAIN: busy_d       = 1'b1;
            S_HOLD:           res_valid_d  = 1'b1;
            default:          ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            load_ready_q <= load_ready_d;
            busy_q       <= busy_d;
            res_valid_q  <= res_valid_d;
        end
    end

    // Row presented to the core next cycle; zero whenever nothing is issued
    always_comb begin
        issue_d = 1'b0;
        for (int k = 0; k < NS; k++) begin
            issue_row[k] = '0;
        end
        if (!abort) begin
            if (state_q == S_IDLE && bus.load_valid) begin
                issue_d = 1'b1;
                for (int k = 0; k < NS; k++) begin
                    issue_row[k] = plane_in[k][0];
                end
            end else if (state_q == S_ISSUE && !last_issue) begin
                issue_d = 1'b1;
                for (int k = 0; k < NS; k++) begin
                    issue_row[k] = plane_q[k][ir_next];
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NS; k++) begin
            cap_row[k] = REV_OUT ? rev_row(core_out[k]) : core_out[k];
        end
    end

    // Datapath: plane/result registers, counters and capture pipe, share lanes kept apart
    always_ff @(posedge clk) begin
        if (rst_i || abort) begin
            for (int k = 0; k < NS; k++) begin
                plane_q[k]   <= '0;
                res_q[k]     <= '0;
                core_in_q[k] <= '0;
            end
            ir_q       <= '0;
            cr_q       <= '0;
            issue_q    <= 1'b0;
            cap_pipe_q <= '0;
        end else begin
            issue_q    <= issue_d;
            cap_pipe_q <= LAT'({cap_pipe_q, issue_q});
            for (int k = 0; k < NS; k++) begin
                core_in_q[k] <= issue_row[k];
            end
            case (state_q)
                S_IDLE: begin
                    if (bus.load_valid) begin
                        for (int k = 0; k < NS; k++) begin
                            plane_q[k] <= plane_in[k];
                        end
                        ir_q <= '0;
                        cr_q <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!last_issue) begin
                        ir_q <= ir_next;
                    end
                end
                S_HOLD: begin
                    if (bus.res_ready) begin
                        for (int k = 0; k < NS; k++) begin
                            plane_q[k] <= '0;
                        end
                    end
                end
                default: ;
            endcase
            if (cap) begin
                for (int k = 0; k < NS; k++) begin
                    res_q[k][cr_q] <= cap_row[k];
                end
                cr_q <= cr_q + CW'(1);
            end
        end
    end

    assign core_in1       = core_in_q[0];
    assign core_in2       = core_in_q[1];
    assign core_in3       = core_in_q[2];
    assign bus.res1       = res_q[0];
    assign bus.res2       = res_q[1];
    assign bus.res3       = res_q[2];
    assign bus.load_ready = load_ready_q;
    assign bus.res_valid  = res_valid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_chi_plane_sched.sv
// Bench for chi_plane_sched: two instances (LAT=1/no reversal, LAT=3/reversing core)
// driven in lockstep and checked against a share-level chi reference.
module tb_chi_plane_sched;
    localparam int NR = 5;
    localparam int PW = 5 * NR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i;
    logic          abort;
    logic          load_valid;
    logic          res_ready;
    logic [PW-1:0] plane [3];
    logic [PW-1:0] cur   [3];

    logic          load_ready_a [2];
    logic          res_valid_a  [2];
    logic          busy_a       [2];
    logic [PW-1:0] res_a        [2][3];
    logic [4:0]    cin_a        [2][3];

    int vectors = 0;
    int errors  = 0;

    function automatic logic [4:0] chi5(input logic [4:0] x);
        logic [4:0] y;
        for (int i = 0; i < 5; i++) y[i] = x[i] ^ (~x[(i + 1) % 5] & x[(i + 2) % 5]);
        return y;
    endfunction

    function automatic logic [4:0] rotl1(input logic [4:0] x);
        return {x[3:0], x[4]};
    endfunction

    function automatic logic [4:0] rev5(input logic [4:0] x);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    // Share-level core behaviour: shares 2 and 3 are mixing masks, share 1 completes chi.
    function automatic logic [4:0] core_f(input int k, input logic [4:0] a,
                                          input logic [4:0] b, input logic [4:0] c);
        logic [4:0] s2;
        logic [4:0] s3;
        s2 = b ^ rotl1(c);
        s3 = c ^ rotl1(a);
        if (k == 0) return chi5(a ^ b ^ c) ^ s2 ^ s3;
        if (k == 1) return s2;
        return s3;
    endfunction

    function automatic logic [PW-1:0] exp_share(input int k, input logic [PW-1:0] a,
                                                input logic [PW-1:0] b, input logic [PW-1:0] c);
        logic [PW-1:0] y;
        for (int r = 0; r < NR; r++) y[5*r +: 5] = core_f(k, a[5*r +: 5], b[5*r +: 5], c[5*r +: 5]);
        return y;
    endfunction

    function automatic logic [PW-1:0] chi_plane(input logic [PW-1:0] x);
        logic [PW-1:0] y;
        for (int r = 0; r < NR; r++) y[5*r +: 5] = chi5(x[5*r +: 5]);
        return y;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LATG = (g == 0) ? 1 : 3;
        localparam bit REVG = (g == 0) ? 1'b0 : 1'b1;

        chi_plane_sched_if #(.NUM_ROWS(NR)) bus ();
        logic [4:0] ci [3];
        logic [4:0] co [3];
        logic [4:0] pipe [LATG][3];
        logic       busy_g;

        assign bus.load_valid = load_valid;
        assign bus.plane1     = plane[0];
        assign bus.plane2     = plane[1];
        assign bus.plane3     = plane[2];
        assign bus.res_ready  = res_ready;

        assign load_ready_a[g] = bus.load_ready;
        assign res_valid_a[g]  = bus.res_valid;
        assign busy_a[g]       = busy_g;
        assign res_a[g][0]     = bus.res1;
        assign res_a[g][1]     = bus.res2;
        assign res_a[g][2]     = bus.res3;
        assign cin_a[g][0]     = ci[0];
        assign cin_a[g][1]     = ci[1];
        assign cin_a[g][2]     = ci[2];

        always @(posedge clk) begin
            for (int k = 0; k < 3; k++) pipe[0][k] <= core_f(k, ci[0], ci[1], ci[2]);
            for (int s = 1; s < LATG; s++)
                for (int k = 0; k < 3; k++) pipe[s][k] <= pipe[s-1][k];
        end

        for (genvar k = 0; k < 3; k++) begin : gen_out
            assign co[k] = REVG ? rev5(pipe[LATG-1][k]) : pipe[LATG-1][k];
        end

        chi_plane_sched #(.NUM_ROWS(NR), .LAT(LATG), .REV_OUT(REVG)) dut (
            .clk       (clk),
            .rst_i     (rst_i),
            .abort     (abort),
            .bus       (bus),
            .core_in1  (ci[0]),
            .core_in2  (ci[1]),
            .core_in3  (ci[2]),
            .core_out1 (co[0]),
            .core_out2 (co[1]),
            .core_out3 (co[2]),
            .busy      (busy_g)
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept_step();
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 3; k++) cur[k] = plane[k];
    endtask

    task automatic start(input logic [PW-1:0] p0, input logic [PW-1:0] p1, input logic [PW-1:0] p2);
        plane[0] = p0;
        plane[1] = p1;
        plane[2] = p2;
        load_valid = 1'b1;
        accept_step();
    endtask

    task automatic check_idle(input string tag, input bit zero_res);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("%s_ctl_u%0d", tag, g),
                {load_ready_a[g], res_valid_a[g], busy_a[g], cin_a[g][0], cin_a[g][1], cin_a[g][2]},
                {1'b1, 1'b0, 1'b0, 15'h0});
            if (zero_res)
                for (int k = 0; k < 3; k++)
                    chk($sformatf("%s_res_u%0d_s%0d", tag, g, k), res_a[g][k], '0);
        end
    endtask

    // Called in the cycle after the accepting edge; leaves the bench with both instances in HOLD.
    task automatic follow(input bit hold10);
        int n [2];
        for (int r = 0; r <= NR; r++) begin
            if (r > 0) step();
            for (int g = 0; g < 2; g++)
                chk($sformatf("issue_r%0d_u%0d", r, g),
                    {busy_a[g], load_ready_a[g], res_valid_a[g], cin_a[g][0], cin_a[g][1], cin_a[g][2]},
                    (r < NR) ? {3'b100, cur[0][5*r +: 5], cur[1][5*r +: 5], cur[2][5*r +: 5]}
                             : {3'b100, 15'h0});
        end
        n[0] = -1;
        n[1] = -1;
        for (int k = NR; k <= 40 && (n[0] < 0 || n[1] < 0); k++) begin
            if (k > NR) step();
            for (int g = 0; g < 2; g++) if (n[g] < 0 && res_valid_a[g]) n[g] = k;
        end
        chk("valid_lat_u0", 32'(n[0]), 32'(NR + 1));
        chk("valid_lat_u1", 32'(n[1]), 32'(NR + 3));
        for (int g = 0; g < 2; g++) begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("res_u%0d_s%0d", g, k), res_a[g][k], exp_share(k, cur[0], cur[1], cur[2]));
            chk($sformatf("xor_u%0d", g), res_a[g][0] ^ res_a[g][1] ^ res_a[g][2],
                chi_plane(cur[0] ^ cur[1] ^ cur[2]));
        end
        if (hold10) begin
            for (int c = 0; c < 10; c++) begin
                step();
                for (int g = 0; g < 2; g++) begin
                    chk($sformatf("hold_ctl_u%0d", g), {res_valid_a[g], load_ready_a[g], busy_a[g]}, 3'b100);
                    for (int k = 0; k < 3; k++)
                        chk($sformatf("hold_res_u%0d_s%0d", g, k), res_a[g][k],
                            exp_share(k, cur[0], cur[1], cur[2]));
                end
            end
        end
    endtask

    task automatic release_res();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        for (int g = 0; g < 2; g++)
            chk($sformatf("release_u%0d", g), {load_ready_a[g], res_valid_a[g], busy_a[g]}, 3'b100);
    endtask

    initial begin
        rst_i      = 1'b1;
        abort      = 1'b0;
        load_valid = 1'b0;
        res_ready  = 1'b0;
        for (int k = 0; k < 3; k++) plane[k] = '0;
        step();
        step();
        rst_i = 1'b0;
        check_idle("reset", 1'b1);

        // All-zero plane: issue timing and valid latency
        start('0, '0, '0);
        follow(1'b0);
        release_res();

        // Share 1 all ones: chi(5'h1F) = 5'h1F per row
        start(25'h1FFFFFF, '0, '0);
        follow(1'b0);
        chk("ones_xor", res_a[0][0] ^ res_a[0][1] ^ res_a[0][2], 25'h1FFFFFF);
        release_res();

        // Backpressure, then a load coinciding with the release handshake
        start(25'($urandom), 25'($urandom), 25'($urandom));
        follow(1'b1);
        plane[0] = 25'($urandom);
        plane[1] = 25'($urandom);
        plane[2] = 25'($urandom);
        load_valid = 1'b1;
        release_res();
        accept_step();
        follow(1'b0);
        release_res();

        // Abort while row 2 is on the core inputs, then an immediate reload
        start(25'($urandom), 25'($urandom), 25'($urandom));
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort", 1'b1);
        start(25'($urandom), 25'($urandom), 25'($urandom));
        follow(1'b0);
        release_res();

        // Reset while the LAT=3 instance still has captures in flight
        start(25'($urandom), 25'($urandom), 25'($urandom));
        for (int c = 0; c < 6; c++) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check_idle("rst_drain", 1'b1);
        for (int c = 0; c < 4; c++) begin
            step();
            check_idle("rst_after", 1'b1);
        end

        // Random regression
        for (int t = 0; t < 1000; t++) begin
            start(25'($urandom), 25'($urandom), 25'($urandom));
            follow(1'b0);
            release_res();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
